// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned FLG_W     = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'd7;
  localparam logic [OPC_W-1:0] OP_PASS = 4'd8;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'd9;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  // Flag vector is {V,N,C,Z}
  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_V = 3;

endpackage

// File: rtl/alu_exec_stage_mul_seq.sv
// Iterative shift-add unsigned multiplier; one partial product per step, done on the WIDTH-th step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // product_c is the accumulator after the current step; final on the done step
  always_comb begin
    product_c = mplier[0] ? (acc + mcand) : acc;
    done_c    = step && (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, multiplicand};
      acc    <= '0;
      mplier <= multiplier;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle logic/arithmetic ops plus an optional iterative multiply.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 9 is treated as illegal.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  output logic              out_valid,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic [3:0]        flags,
  output logic              err
);

  logic              accept_c;
  logic [WIDTH:0]    sum_c;
  logic [WIDTH:0]    diff_c;
  logic [WIDTH-1:0]  alu_res_c;
  logic              alu_carry_c;
  logic              alu_ovf_c;
  logic              alu_ill_c;

  logic              in_ready_d;
  logic              out_valid_d;
  logic [WIDTH-1:0]  result_d;
  logic [WIDTH-1:0]  result_hi_d;
  logic [3:0]        flags_d;
  logic              err_d;

  assign accept_c = in_valid && in_ready;

`ifdef ALU_MUL_EN
  state_t              state;
  state_t              state_d;
  logic                mul_start_c;
  logic                mul_done_c;
  logic [2*WIDTH-1:0]  product_c;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start_c),
    .step         (state == ST_MUL_BUSY),
    .multiplicand (operand_a),
    .multiplier   (operand_b),
    .done_c       (mul_done_c),
    .product_c    (product_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end
`endif

  // Single-cycle datapath
  always_comb begin
    sum_c       = {1'b0, operand_a} + {1'b0, operand_b};
    diff_c      = {1'b0, operand_a} - {1'b0, operand_b};
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    alu_ill_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res_c   = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
        alu_ovf_c   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (sum_c[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c   = diff_c[WIDTH-1:0];
        alu_carry_c = diff_c[WIDTH];
        alu_ovf_c   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                      (diff_c[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND:  alu_res_c = operand_a & operand_b;
      OP_OR:   alu_res_c = operand_a | operand_b;
      OP_XOR:  alu_res_c = operand_a ^ operand_b;
      OP_NOT:  alu_res_c = ~operand_a;
      OP_SHL: begin
        alu_res_c   = {operand_a[WIDTH-2:0], 1'b0};
        alu_carry_c = operand_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res_c   = {1'b0, operand_a[WIDTH-1:1]};
        alu_carry_c = operand_a[0];
      end
      OP_PASS: alu_res_c = operand_b;
      default: alu_ill_c = 1'b1;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    result_d    = result;
    result_hi_d = result_hi;
    flags_d     = flags;
    err_d       = err;
`ifdef ALU_MUL_EN
    state_d     = state;
    mul_start_c = 1'b0;
    if (state == ST_MUL_BUSY) begin
      in_ready_d = 1'b0;
      if (mul_done_c) begin
        state_d        = ST_IDLE;
        in_ready_d     = 1'b1;
        out_valid_d    = 1'b1;
        result_d       = product_c[WIDTH-1:0];
        result_hi_d    = product_c[2*WIDTH-1:WIDTH];
        err_d          = 1'b0;
        flags_d        = '0;
        flags_d[FLG_Z] = (product_c == '0);
        flags_d[FLG_N] = product_c[WIDTH-1];
        flags_d[FLG_C] = |product_c[2*WIDTH-1:WIDTH];
      end
    end else if (accept_c && (opcode == OP_MUL)) begin
      state_d     = ST_MUL_BUSY;
      mul_start_c = 1'b1;
      in_ready_d  = 1'b0;
    end else
`endif
    if (accept_c) begin
      out_valid_d    = 1'b1;
      result_d       = alu_res_c;
      result_hi_d    = '0;
      err_d          = alu_ill_c;
      flags_d        = '0;
      flags_d[FLG_Z] = (alu_res_c == '0);
      flags_d[FLG_N] = alu_res_c[WIDTH-1];
      flags_d[FLG_C] = alu_carry_c;
      flags_d[FLG_V] = alu_ovf_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      result_hi <= result_hi_d;
      flags     <= flags_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed corner cases plus randomized ops vs an arithmetic model.
module tb_alu_exec_stage;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       out_valid;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] flags;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 8-bit unsigned values; flags packed {V,N,C,Z}
  function automatic void model(input int op, input int a, input int b,
                                output int res, output int hi, output int fl, output int er);
    int sa, sb, sv, full;
    bit c, v, ill;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0; ill = 0; hi = 0; res = 0;
    case (op)
      0: begin full = a + b; res = full % 256; c = (full > 255); sv = sa + sb; v = (sv > 127) || (sv < -128); end
      1: begin res = (a - b + 256) % 256; c = (a < b); sv = sa - sb; v = (sv > 127) || (sv < -128); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: begin res = (a * 2) % 256; c = (a >= 128); end
      7: begin res = a / 2; c = (a % 2 == 1); end
      8: res = b;
      9: if (MUL_EN) begin full = a * b; res = full % 256; hi = full / 256; c = (hi != 0); end
         else ill = 1;
      default: ill = 1;
    endcase
    er = ill;
    fl = (int'(v) << 3) | (int'(res >= 128) << 2) | (int'(c) << 1) | int'(res == 0 && hi == 0);
  endfunction

  function automatic int latency(input int op);
    return (op == 9 && MUL_EN) ? 9 : 1;
  endfunction

  function automatic int pick();
    int corner [4] = '{0, 127, 128, 255};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return int'($urandom_range(0, 255));
  endfunction

  task automatic check_outputs(input string tag, input int res, input int hi, input int fl, input int er);
    check({tag, ".result"}, int'(result), res);
    check({tag, ".result_hi"}, int'(result_hi), hi);
    check({tag, ".flags"}, int'(flags), fl);
    check({tag, ".err"}, int'(err), er);
  endtask

  // Issue one op from idle, scramble inputs after acceptance, and check timing and results
  task automatic run_op(input string tag, input int op, input int a, input int b);
    int res, hi, fl, er, n, low;
    model(op, a, b, res, hi, fl, er);
    @(negedge clk);
    check({tag, ".ready_in"}, int'(in_ready), 1);
    in_valid = 1'b1; opcode = 4'(op); operand_a = 8'(a); operand_b = 8'(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0; opcode = 4'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
    n = 0; low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) low++;
    end while (!out_valid && n < 20);
    check({tag, ".latency"}, n, latency(op));
    check({tag, ".ready_low"}, low, latency(op) - 1);
    check_outputs(tag, res, hi, fl, er);
    @(negedge clk);
    check({tag, ".pulse"}, int'(out_valid), 0);
    check({tag, ".hold"}, int'(flags), fl);
  endtask

  initial begin
    int res, hi, fl, er, n, ov_seen;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst.out_valid", int'(out_valid), 0);
    check_outputs("rst", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.in_ready", int'(in_ready), 1);

    run_op("add_ovf", 0, 'h7F, 'h01);
    run_op("add_wrap", 0, 'hFF, 'h01);
    run_op("sub_borrow", 1, 'h00, 'h01);

    // Back-to-back AND then SHR
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd2; operand_a = 8'hF0; operand_b = 8'h3C;
    @(negedge clk);
    model(2, 'hF0, 'h3C, res, hi, fl, er);
    check("b2b_and.valid", int'(out_valid), 1);
    check_outputs("b2b_and", res, hi, fl, er);
    opcode = 4'd7; operand_a = 8'h01; operand_b = 8'h00;
    @(negedge clk);
    model(7, 'h01, 'h00, res, hi, fl, er);
    check("b2b_shr.valid", int'(out_valid), 1);
    check_outputs("b2b_shr", res, hi, fl, er);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b.pulse", int'(out_valid), 0);

    run_op("mul_0f11", 9, 'h0F, 'h11);
    run_op("mul_ffff", 9, 'hFF, 'hFF);

    // ADD held on in_valid while a multiply occupies the stage
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd9; operand_a = 8'hA5; operand_b = 8'h3B;
    @(posedge clk);
    #1;
    opcode = 4'd0; operand_a = 8'h22; operand_b = 8'h33;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    check("held.wait", n, latency(9));
    check("held.mul_valid", int'(out_valid), 1);
    model(9, 'hA5, 'h3B, res, hi, fl, er);
    check_outputs("held.mul", res, hi, fl, er);
    @(negedge clk);
    in_valid = 1'b0;
    model(0, 'h22, 'h33, res, hi, fl, er);
    check("held.add_valid", int'(out_valid), 1);
    check_outputs("held.add", res, hi, fl, er);
    @(negedge clk);
    check("held.pulse", int'(out_valid), 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd9; operand_a = 8'h12; operand_b = 8'h34;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("midrst.out_valid", int'(out_valid), 0);
    check_outputs("midrst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1;
    end
    check("midrst.no_valid", ov_seen, 0);
    run_op("post_rst_add", 0, 'h01, 'h01);

    // Illegal opcodes and err clearing
    run_op("illegal_f", 15, 'h5A, 'hA5);
    run_op("clear_err", 3, 'h12, 'h40);
    run_op("op9", 9, 'h03, 'h05);
    run_op("illegal_a", 10, 'h80, 'h80);
    run_op("clear_err2", 8, 'h00, 'h7E);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("rand", int'($urandom_range(0, 15)), pick(), pick());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
